uart_tx_buffered: RTL and testbench
===================================

# uart_tx_buffered

Buffered UART transmitter: the send-side counterpart of the receive path in the counter/UART top level. It accepts bytes over a valid/ready handshake into a small FIFO and serialises them on `o_tx` as 8N1 frames (start bit, 8 data bits LSB first, stop bit). Clocked from the `clk_gen` output clock. Sits between byte producers (counter, loopback of received data) and the board TX pin.

## Interface

**Parameters**
- `CLKS_PER_BIT`, default 868: clock cycles per UART bit; legal range ≥ 2.
- `FIFO_DEPTH`, default 8: byte entries; must be a power of two, ≥ 2.

**Ports**
- `clk`, input, 1: single clock; all logic on the rising edge.
- `i_reset_n`, input, 1: asynchronous, active-low reset.
- `i_data`, input, 8: byte to enqueue.
- `i_valid`, input, 1: `i_data` is valid this cycle.
- `o_ready`, output, 1: FIFO can accept a byte.
- `o_tx`, output, 1: serial line; idles high.
- `o_busy`, output, 1: a frame is in progress.
- `o_fifo_count`, output, log2(FIFO_DEPTH)+1: number of queued bytes, excluding the byte in flight.

## Operation

**Write handshake**
- A byte is accepted on a rising edge where `i_valid && o_ready`.
- `o_ready = (o_fifo_count != FIFO_DEPTH)`, derived only from registered count.
- A write while full is ignored, even if a pop occurs in the same cycle.

**FIFO**
- Circular buffer with read/write pointers of log2(FIFO_DEPTH) bits that wrap modulo depth.
- Count changes as follows on an edge:
  - +1 on write only.
  - −1 on pop only.
  - Unchanged on simultaneous write and pop.

**FSM states:** IDLE, START, DATA, STOP.
- **IDLE:** `o_tx`=1. If count>0, pop the head into the shift register, clear the bit counter and baud counter, and go to START.
- **START:** `o_tx`=0 for CLKS_PER_BIT cycles, then go to DATA.
- **DATA:** `o_tx` = shift[0] for CLKS_PER_BIT cycles per bit, shifting right after each bit. After bit 7, go to STOP.
- **STOP:** `o_tx`=1 for CLKS_PER_BIT cycles. On the final stop cycle:
  - if count>0, pop and go directly to START (back-to-back frames);
  - otherwise go to IDLE.
- **Baud counter:** runs 0..CLKS_PER_BIT-1. The state or bit advances when it equals CLKS_PER_BIT-1; the counter then returns to 0.
- `o_busy = (state != IDLE)`.
- `o_tx` is a registered output, glitch-free.

**Reset**
- Asserting `i_reset_n`=0 at any time, including mid-frame, immediately forces:
  - `o_tx`=1, `o_busy`=0, `o_fifo_count`=0, `o_ready`=1, state IDLE;
  - pointers, counters and shift register to 0.
- Queued and in-flight bytes are discarded; a partial frame is simply truncated.
- After deassertion, no activity occurs until a byte is written.

## Timing

- **Reset values:**
  - `o_tx`=1
  - `o_busy`=0
  - `o_ready`=1
  - `o_fifo_count`=0
- **Latency:** byte accepted at edge k → count=1 after edge k → popped at edge k+1 → `o_tx` falls after edge k+1 (2 edges after acceptance) and `o_busy` rises at the same time.
- **Frame length:** exactly 10×CLKS_PER_BIT cycles from `o_tx` falling to the end of the stop bit.
- **Back-to-back:** consecutive frames start 10×CLKS_PER_BIT cycles apart, with no idle gap.
- **Isolated frame:** `o_busy` falls after the stop bit's last cycle.
- **FIFO and the in-flight byte:** a pop frees one slot. A full FIFO plus one byte in flight holds FIFO_DEPTH+1 bytes total.
- **Data capture:** `i_data` is only sampled on accept edges; it may change freely otherwise.

## Test plan

Sim parameters: CLKS_PER_BIT=4, FIFO_DEPTH=4.

1. **Reset idle.** Hold `i_reset_n`=0 for 3 cycles, then release → `o_tx`=1, `o_ready`=1, `o_busy`=0, count=0 for 20 idle cycles.
2. **Single byte.** Write 0xA5 → `o_tx` falls 2 edges later. Line sequence is 0 (start), then bits 1,0,1,0,0,1,0,1, then 1 (stop), each held exactly 4 cycles (40 total). `o_busy` then deasserts.
3. **Back-to-back and full.** Write 0x01, 0x02, 0x03, 0x04, 0x05 on consecutive cycles:
   - first byte pops, so all five are accepted;
   - `o_ready` drops after the fifth;
   - a sixth write with 0xFF is ignored;
   - line shows five frames spaced exactly 40 cycles, 0x01..0x05 in order, no 0xFF.
4. **Simultaneous write/pop.** With count=2, assert `i_valid` on the cycle a frame's stop bit ends → count stays 2, and the next frame starts with no gap.
5. **Reset mid-frame.** Assert reset during data bit 3 of 0x3C with 2 bytes queued → `o_tx`=1 and count=0 asynchronously. After release, nothing is transmitted. A new write of 0x55 produces a clean frame.
6. **Pointer wrap.** Stream 12 bytes 0x10..0x1B with `i_valid` held, honouring `o_ready` → all 12 frames are received in order, with correct data across 3 pointer wraps.

Source files
------------

// File: rtl/uart_tx_buffered.sv
// -----------------------------------------------------------------------------
// uart_tx_buffered
// Buffered 8N1 UART transmitter. Bytes arrive over a valid/ready handshake into
// a small circular FIFO. They are serialised LSB first on o_tx, framed by one
// start bit and one stop bit. When another byte is queued, frames run
// back-to-back with no idle gap.
//
// Ports
//   clk           rising-edge clock
//   i_reset_n     asynchronous active-low reset; discards queued and in-flight data
//   i_data        byte to enqueue
//   i_valid       i_data valid this cycle
//   o_ready       FIFO can accept a byte (from the registered count only)
//   o_tx          serial line, registered, idles high
//   o_busy        a frame is in progress
//   o_fifo_count  queued bytes, excluding the byte being shifted out
// -----------------------------------------------------------------------------
module uart_tx_buffered #(
   parameter int CLKS_PER_BIT = 868,
   parameter int FIFO_DEPTH   = 8
) (
   input  logic                         clk,
   input  logic                         i_reset_n,
   input  logic [7:0]                   i_data,
   input  logic                         i_valid,
   output logic                         o_ready,
   output logic                         o_tx,
   output logic                         o_busy,
   output logic [$clog2(FIFO_DEPTH):0]  o_fifo_count
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int BW = $clog2(CLKS_PER_BIT);
   localparam logic [BW-1:0] BAUD_LAST  = BW'(CLKS_PER_BIT - 1);
   localparam logic [PW:0]   COUNT_FULL = (PW+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   state_t          state_q, state_d;
   logic [BW-1:0]   baud_q, baud_d;
   logic [2:0]      bit_q, bit_d;
   logic [7:0]      shift_q, shift_d;
   logic            tx_q, tx_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PW:0]     count_q, count_d;
   logic [7:0]      mem_q [FIFO_DEPTH];

   logic            wr_en;
   logic            pop;
   logic            baud_done;
   logic            fifo_nonempty;

   // A write while full is dropped even if a pop frees a slot on the same edge.
   assign o_ready       = (count_q != COUNT_FULL);
   assign wr_en         = i_valid && o_ready;
   assign baud_done     = (baud_q == BAUD_LAST);
   assign fifo_nonempty = (count_q != '0);

   assign o_tx         = tx_q;
   assign o_busy       = (state_q != S_IDLE);
   assign o_fifo_count = count_q;

   // FIFO pointers and occupancy
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)   rd_ptr_d = rd_ptr_q + PW'(1);
      if (wr_en && !pop)      count_d = count_q + (PW+1)'(1);
      else if (pop && !wr_en) count_d = count_q - (PW+1)'(1);
   end

   // Frame sequencer. tx_d is computed for the state being entered, so the
   // line register changes on the same edge as the state.
   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      tx_d    = tx_q;
      pop     = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            tx_d = 1'b1;
            if (fifo_nonempty) begin
               pop     = 1'b1;
               shift_d = mem_q[rd_ptr_q];
               bit_d   = '0;
               baud_d  = '0;
               state_d = S_START;
               tx_d    = 1'b0;
            end
         end
         S_START: begin
            if (baud_done) begin
               baud_d  = '0;
               state_d = S_DATA;
               tx_d    = shift_q[0];
            end else begin
               baud_d = baud_q + BW'(1);
            end
         end
         S_DATA: begin
            if (baud_done) begin
               baud_d  = '0;
               shift_d = {1'b0, shift_q[7:1]};
               if (bit_q == 3'd7) begin
                  state_d = S_STOP;
                  tx_d    = 1'b1;
               end else begin
                  bit_d = bit_q + 3'd1;
                  tx_d  = shift_q[1];
               end
            end else begin
               baud_d = baud_q + BW'(1);
            end
         end
         S_STOP: begin
            if (baud_done) begin
               baud_d = '0;
               // Chain straight into the next start bit when data is waiting.
               if (fifo_nonempty) begin
                  pop     = 1'b1;
                  shift_d = mem_q[rd_ptr_q];
                  bit_d   = '0;
                  state_d = S_START;
                  tx_d    = 1'b0;
               end else begin
                  state_d = S_IDLE;
                  tx_d    = 1'b1;
               end
            end else begin
               baud_d = baud_q + BW'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q  <= S_IDLE;
         baud_q   <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         tx_q     <= 1'b1;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         baud_q   <= baud_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         tx_q     <= tx_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: an entry is only read after it has been written.
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q] <= i_data;
   end

endmodule

// File: tb/tb_uart_tx_buffered.sv
module tb_uart_tx_buffered;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;
   localparam int FRAME = 10 * CPB;

   logic                     clk = 1'b0;
   logic                     i_reset_n;
   logic [7:0]               i_data;
   logic                     i_valid;
   logic                     o_ready;
   logic                     o_tx;
   logic                     o_busy;
   logic [$clog2(DEPTH):0]   o_fifo_count;

   int        n_checks = 0;
   int        n_fail   = 0;
   int        cyc      = 0;
   logic [7:0] exp_q[$];
   int        start_q[$];

   uart_tx_buffered #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
      .clk          (clk),
      .i_reset_n    (i_reset_n),
      .i_data       (i_data),
      .i_valid      (i_valid),
      .o_ready      (o_ready),
      .o_tx         (o_tx),
      .o_busy       (o_busy),
      .o_fifo_count (o_fifo_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Line monitor: decodes a frame from 40 negedge samples after a low start.
   initial begin
      logic [39:0] smp;
      logic [7:0]  rx;
      logic        aborted;
      logic        shape_ok;
      forever begin
         @(negedge clk);
         if (i_reset_n === 1'b1 && o_tx === 1'b0) begin
            start_q.push_back(cyc);
            smp     = '0;
            aborted = 1'b0;
            for (int i = 1; i < FRAME; i++) begin
               @(negedge clk);
               if (i_reset_n !== 1'b1) begin
                  aborted = 1'b1;
                  break;
               end
               smp[i] = o_tx;
            end
            if (!aborted) begin
               shape_ok = 1'b1;
               for (int g = 0; g < 10; g++)
                  for (int j = 1; j < CPB; j++)
                     if (smp[g*CPB+j] !== smp[g*CPB]) shape_ok = 1'b0;
               chk("frame_shape", {31'd0, shape_ok}, 32'd1);
               chk("stop_bit", {31'd0, smp[9*CPB]}, 32'd1);
               for (int b = 0; b < 8; b++) rx[b] = smp[(b+1)*CPB];
               if (exp_q.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL unexpected_frame: got 0x%0h, expected no frame", rx);
               end else begin
                  chk("frame_data", {24'd0, rx}, {24'd0, exp_q.pop_front()});
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   // Drive one byte across the next rising edge; leaves i_valid high.
   task automatic write(input logic [7:0] b);
      i_data  = b;
      i_valid = 1'b1;
      @(negedge clk);
   endtask

   task automatic drain();
      for (int i = 0; i < 3000; i++) begin
         if (exp_q.size() == 0 && o_busy === 1'b0) break;
         @(negedge clk);
      end
      chk("drain_done", {31'd0, (exp_q.size() == 0 && o_busy === 1'b0)}, 32'd1);
      repeat (3) @(negedge clk);
   endtask

   task automatic chk_spacing(input int n);
      chk("frame_count", start_q.size(), n);
      for (int i = 1; i < start_q.size(); i++)
         chk("frame_spacing", start_q[i] - start_q[i-1], FRAME);
   endtask

   initial begin
      logic idle_bad;
      logic acc;
      int   waited;

      i_reset_n = 1'b0;
      i_valid   = 1'b0;
      i_data    = 8'h00;

      // Reset and idle
      repeat (3) @(negedge clk);
      chk("rst_tx", o_tx, 1);
      chk("rst_busy", o_busy, 0);
      chk("rst_ready", o_ready, 1);
      chk("rst_count", o_fifo_count, 0);
      i_reset_n = 1'b1;
      repeat (20) begin
         @(negedge clk);
         chk("idle_tx", o_tx, 1);
         chk("idle_busy", o_busy, 0);
         chk("idle_ready", o_ready, 1);
         chk("idle_count", o_fifo_count, 0);
      end

      // Single byte 0xA5
      exp_q.push_back(8'hA5);
      write(8'hA5);
      i_valid = 1'b0;
      chk("a5_count_after_accept", o_fifo_count, 1);
      chk("a5_tx_still_high", o_tx, 1);
      chk("a5_busy_not_yet", o_busy, 0);
      @(negedge clk);
      chk("a5_tx_falls", o_tx, 0);
      chk("a5_busy_rises", o_busy, 1);
      chk("a5_count_popped", o_fifo_count, 0);
      repeat (FRAME - 1) @(negedge clk);
      chk("a5_busy_last_stop", o_busy, 1);
      @(negedge clk);
      chk("a5_busy_falls", o_busy, 0);
      chk("a5_tx_idle", o_tx, 1);
      chk("a5_received", exp_q.size(), 0);

      // Back-to-back fill to full, sixth write ignored
      start_q.delete();
      for (int i = 1; i <= 5; i++) exp_q.push_back(8'(i));
      write(8'h01);
      write(8'h02);
      write(8'h03);
      write(8'h04);
      write(8'h05);
      chk("full_ready_low", o_ready, 0);
      chk("full_count", o_fifo_count, 4);
      write(8'hFF);
      i_valid = 1'b0;
      chk("full_ignored_count", o_fifo_count, 4);
      chk("full_ready_still_low", o_ready, 0);
      drain();
      chk_spacing(5);

      // Simultaneous write and pop with count=2
      start_q.delete();
      exp_q.push_back(8'h61);
      exp_q.push_back(8'h62);
      exp_q.push_back(8'h63);
      exp_q.push_back(8'h64);
      write(8'h61);
      write(8'h62);
      write(8'h63);
      i_valid = 1'b0;
      repeat (FRAME - 2) @(negedge clk);
      chk("simul_count_before", o_fifo_count, 2);
      write(8'h64);
      i_valid = 1'b0;
      chk("simul_count_after", o_fifo_count, 2);
      chk("simul_next_start", o_tx, 0);
      chk("simul_busy", o_busy, 1);
      drain();
      chk_spacing(4);

      // Reset during data bit 3 of 0x3C with two bytes queued
      exp_q.push_back(8'h3C);
      write(8'h3C);
      write(8'hAA);
      write(8'hBB);
      i_valid = 1'b0;
      chk("mid_count_queued", o_fifo_count, 2);
      repeat (16) @(negedge clk);
      chk("mid_busy_before", o_busy, 1);
      i_reset_n = 1'b0;
      exp_q.delete();
      #1;
      chk("mid_rst_tx", o_tx, 1);
      chk("mid_rst_count", o_fifo_count, 0);
      chk("mid_rst_busy", o_busy, 0);
      chk("mid_rst_ready", o_ready, 1);
      repeat (3) @(negedge clk);
      i_reset_n = 1'b1;
      idle_bad = 1'b0;
      repeat (60) begin
         @(negedge clk);
         if (o_tx !== 1'b1 || o_busy !== 1'b0 || o_fifo_count !== '0) idle_bad = 1'b1;
      end
      chk("post_reset_silent", idle_bad, 0);
      exp_q.push_back(8'h55);
      write(8'h55);
      i_valid = 1'b0;
      drain();

      // Pointer wrap: 12 bytes streamed while honouring o_ready
      for (int i = 0; i < 12; i++) begin
         exp_q.push_back(8'h10 + 8'(i));
         i_data  = 8'h10 + 8'(i);
         i_valid = 1'b1;
         waited  = 0;
         acc     = 1'b0;
         while (!acc && waited < 500) begin
            acc = o_ready;
            @(negedge clk);
            waited++;
         end
         if (!acc) chk("wrap_accept_timeout", 0, 1);
      end
      i_valid = 1'b0;
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
